fifo_sync_buffer: RTL
=====================

// Module: fifo_sync_buffer
// PURPOSE
//  Single-clock FIFO that succeeds the dual-port FIFO storage: RAM array plus pointer, occupancy and flag logic in one block.
//  Parametrised width/depth, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags.
//  Selectable read mode: standard (registered read, 1-cycle latency) or first-word-fall-through (FWFT).
//  Used wherever producer and consumer share wclk, replacing the async FIFO pair where no clock crossing exists.
// PARAMETERS
//  DATASIZE   32   data word width (bits)
//  ADDRSIZE   5    address bits; DEPTH = 1<<ADDRSIZE words
//  AFULL_TH   28   walmost_full asserted when count >= AFULL_TH (1..DEPTH)
//  AEMPTY_TH  4    ralmost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)
//  FWFT       0    0 = standard read mode, 1 = first-word-fall-through
// PORTS
//  wclk           in   1           single clock, all logic on rising edge
//  wrst           in   1           synchronous reset, active-high
//  winc           in   1           write request
//  wdata          in   DATASIZE    write data
//  rinc           in   1           read request (FWFT: pop of presented word)
//  rdata          out  DATASIZE    read data
//  rvalid         out  1           rdata holds a valid word (see BEHAVIOUR)
//  wfull          out  1           count == DEPTH
//  rempty         out  1           no word available to read
//  walmost_full   out  1           count >= AFULL_TH
//  ralmost_empty  out  1           count <= AEMPTY_TH
//  count          out  ADDRSIZE+1  words held (RAM plus FWFT output register)
//  overflow       out  1           sticky: write attempted while wfull
//  underflow      out  1           sticky: read attempted while rempty
// BEHAVIOUR
//  Reset (wrst=1 at an edge): pointers=0, count=0, rdata=0, rvalid=0, rempty=1, wfull=0, overflow=underflow=0,
//   ralmost_empty=1, walmost_full=0. RAM contents are not cleared. Mid-operation reset discards all data; next cycle reads as empty.
//  Pointers: ADDRSIZE-bit binary waddr/raddr, wrap from DEPTH-1 to 0 with no gap.
//  Accept rules use current-cycle registered flags: write accepted iff winc && !wfull; read accepted iff rinc && !rempty.
//  Rejected write: RAM, waddr, count unchanged; overflow<=1. Rejected read: rdata/raddr/count unchanged; underflow<=1.
//   Sticky flags clear only on wrst.
//  count: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither; never exceeds DEPTH or drops below 0.
//  Flags wfull, walmost_full, ralmost_empty are decoded from the count register (no combinational path from winc/rinc).
//  Simultaneous winc+rinc when empty: write accepted, read rejected, underflow set. When full: read accepted, write rejected, overflow set.
//  Simultaneous accepted write and read at any level in between: both occur, count holds.
//  Standard mode (FWFT=0): rempty = (count==0). Accepted read at edge N -> rdata = mem[raddr] after edge N, rvalid=1 for that one cycle.
//   rdata holds its last value otherwise. Write-to-readable latency 1 cycle (rempty falls after the write edge).
//  FWFT mode (FWFT=1): output register prefetches head word whenever it is empty or being popped and RAM holds data.
//   rvalid=1 while it holds a word; rempty = !rvalid. rinc pops the presented word.
//   Write into empty FIFO at edge N -> RAM write at N, prefetch at N+1, rvalid=1 after N+1 (2-cycle latency).
//   count includes the output-register word; total capacity stays DEPTH.
//  Read data never bypasses RAM: a word written at edge N is not readable in the same cycle.
// TESTING (DATASIZE=8, ADDRSIZE=2, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1)
//  Reset then idle -> rempty=1, wfull=0, count=0, ralmost_empty=1, rdata=0, overflow=underflow=0.
//  Write 0xA1,0xA2,0xA3,0xA4, then a 5th winc (0xFF) -> wfull=1 and count=4 after the 4th write, walmost_full=1 from count=3;
//   5th rejected, overflow=1, count stays 4.
//  Standard mode, read 4 times -> rdata 0xA1..0xA4 one cycle after each rinc; rvalid pulses; rempty=1 after the 4th read.
//   A 5th rinc sets underflow=1 and rdata stays 0xA4.
//  Fill to 4, assert winc+rinc together -> read returns oldest word, write rejected, overflow=1, count=3.
//   At count=2, winc+rinc together -> count stays 2 and the order is preserved.
//  Wrap: 10 rounds of write-2/read-2 -> data order intact across pointer wrap; count returns to 0.
//  FWFT=1: write 0x5C into empty FIFO at edge N -> rvalid=1 and rdata=0x5C after N+1; rinc pops it -> rempty=1, count=0.
//   Apply wrst mid-fill (count=3) -> next cycle count=0, rempty=1, rvalid=0.

Source files
------------

// File: rtl/fifo_sync_buffer.sv
// Single-clock FIFO: RAM array, binary pointers, occupancy counter and
// status flags in one block. Supports a registered (1-cycle latency) read
// mode and a first-word-fall-through mode selected by the FWFT parameter.
module fifo_sync_buffer #(
    parameter int DATASIZE  = 32,
    parameter int ADDRSIZE  = 5,
    parameter int AFULL_TH  = 28,
    parameter int AEMPTY_TH = 4,
    parameter bit FWFT      = 1'b0
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    output logic                wfull,
    output logic                rempty,
    output logic                walmost_full,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = 1 << ADDRSIZE;

    localparam logic [ADDRSIZE:0]   L_DEPTH   = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0]   L_AFULL   = (ADDRSIZE+1)'(AFULL_TH);
    localparam logic [ADDRSIZE:0]   L_AEMPTY  = (ADDRSIZE+1)'(AEMPTY_TH);
    localparam logic [ADDRSIZE:0]   L_CNT_ONE = (ADDRSIZE+1)'(1);
    localparam logic [ADDRSIZE-1:0] L_PTR_ONE = ADDRSIZE'(1);

    logic [DATASIZE-1:0] r_mem [DEPTH];
    logic [ADDRSIZE-1:0] r_waddr;
    logic [ADDRSIZE-1:0] r_raddr;
    logic [ADDRSIZE:0]   r_count;
    logic [DATASIZE-1:0] r_rdata;
    logic                r_rvalid;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_full;
    logic                w_empty;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [ADDRSIZE:0]   w_ram_cnt;
    logic                w_fetch;

    // Accept decisions and RAM fetch strobe, all from registered state.
    // In FWFT mode the output register holds one of the counted words, so
    // the RAM itself holds count minus that word; a fetch refills the output
    // register whenever it is empty or being popped and the RAM has data.
    always_comb begin
        w_full    = (r_count == L_DEPTH);
        w_empty   = FWFT ? !r_rvalid : (r_count == '0);
        w_wr_acc  = winc && !w_full;
        w_rd_acc  = rinc && !w_empty;
        w_ram_cnt = FWFT ? (r_count - {{ADDRSIZE{1'b0}}, r_rvalid}) : r_count;
        w_fetch   = FWFT ? ((!r_rvalid || w_rd_acc) && (w_ram_cnt != '0))
                         : w_rd_acc;
    end

    // Storage array: written on accepted writes only, never reset.
    always_ff @(posedge wclk) begin
        if (w_wr_acc) begin
            r_mem[r_waddr] <= wdata;
        end
    end

    // Pointers and occupancy counter; pointers wrap naturally at DEPTH.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_waddr <= '0;
            r_raddr <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) begin
                r_waddr <= r_waddr + L_PTR_ONE;
            end
            if (w_fetch) begin
                r_raddr <= r_raddr + L_PTR_ONE;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + L_CNT_ONE;
            end else if (!w_wr_acc && w_rd_acc) begin
                r_count <= r_count - L_CNT_ONE;
            end
        end
    end

    // Output data register and its valid flag. Standard mode pulses valid
    // for the cycle after an accepted read; FWFT keeps valid while a word
    // is presented and drops it when the word is popped with nothing behind.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_rdata <= r_mem[r_raddr];
            end
            if (FWFT) begin
                r_rvalid <= w_fetch || (r_rvalid && !w_rd_acc);
            end else begin
                r_rvalid <= w_rd_acc;
            end
        end
    end

    // Sticky error flags: set by any rejected request, cleared only by reset.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (winc && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rinc && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign rdata         = r_rdata;
    assign rvalid        = r_rvalid;
    assign wfull         = w_full;
    assign rempty        = w_empty;
    assign walmost_full  = (r_count >= L_AFULL);
    assign ralmost_empty = (r_count <= L_AEMPTY);
    assign count         = r_count;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule
